// File: rtl/uart_rx.sv
// Bus-attached 8N1 UART receiver: synchroniser, receive FSM, byte FIFO and
// RXDATA/STATUS/CTRL registers with a level interrupt while data is pending.
module uart_rx #(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned BaudRate       = 115_200,
  parameter int unsigned FifoDepth      = 8
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_ni,
  input  logic        device_req_i,
  input  logic [31:0] device_addr_i,
  input  logic        device_we_i,
  input  logic [3:0]  device_be_i,
  input  logic [31:0] device_wdata_i,
  output logic        device_rvalid_o,
  output logic [31:0] device_rdata_o,
  input  logic        uart_rx_i,
  output logic        rx_irq_o
);

  localparam int unsigned ClocksPerBit = ClockFrequency / BaudRate;
  localparam int unsigned CntW         = $clog2(ClocksPerBit);
  localparam int unsigned PtrW         = $clog2(FifoDepth);
  localparam logic [CntW-1:0] CntFull  = CntW'(ClocksPerBit - 1);
  localparam logic [CntW-1:0] CntHalf  = CntW'(ClocksPerBit / 2 - 1);
  localparam logic [PtrW:0]   FullCnt  = (PtrW + 1)'(FifoDepth);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_r;
  logic [CntW-1:0] cnt_r;
  logic [2:0]      idx_r;
  logic [7:0]      shift_r;
  logic            sync1_r, sync2_r, prev_r;

  logic [7:0]      mem_r [FifoDepth];
  logic [PtrW-1:0] wr_ptr_r, rd_ptr_r;
  logic [PtrW:0]   count_r;
  logic            overrun_r, frame_err_r, irq_en_r, irq_r;
  logic            rvalid_r;
  logic [31:0]     rdata_r;

  logic            rd_s, wr_s, empty_s, full_s, pop_s, push_s, push_ok_s;
  logic            ferr_s, ovr_set_s, irq_en_next_s;
  logic [1:0]      sel_s;
  logic [PtrW:0]   count_next_s;
  logic [31:0]     rdata_next_s;
  logic            unused_s;

  assign unused_s = ^{device_be_i, device_addr_i[31:4], device_addr_i[1:0],
                      device_wdata_i[31:4], device_wdata_i[1]};

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= uart_rx_i;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Receive FSM: mid-bit sampling with a half-bit delay from the start edge.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (prev_r && !sync2_r) begin
            cnt_r   <= CntHalf;
            state_r <= START;
          end
        end
        START: begin
          if (cnt_r == '0) begin
            if (!sync2_r) begin
              cnt_r   <= CntFull;
              idx_r   <= 3'd0;
              state_r <= DATA;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        DATA: begin
          if (cnt_r == '0) begin
            shift_r[idx_r] <= sync2_r;
            cnt_r          <= CntFull;
            if (idx_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        STOP: begin
          if (cnt_r == '0) begin
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Bus decode, FIFO control and next-state values for the registered outputs.
  always_comb begin
    rd_s          = device_req_i && !device_we_i;
    wr_s          = device_req_i && device_we_i;
    sel_s         = device_addr_i[3:2];
    empty_s       = (count_r == '0);
    full_s        = (count_r == FullCnt);
    push_s        = (state_r == STOP) && (cnt_r == '0) && sync2_r;
    ferr_s        = (state_r == STOP) && (cnt_r == '0) && !sync2_r;
    pop_s         = rd_s && (sel_s == 2'd0) && !empty_s;
    push_ok_s     = push_s && (!full_s || pop_s);
    ovr_set_s     = push_s && full_s && !pop_s;
    irq_en_next_s = irq_en_r;
    if (wr_s && (sel_s == 2'd2)) begin
      irq_en_next_s = device_wdata_i[0];
    end else begin
      irq_en_next_s = irq_en_r;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_next_s = count_r + 1'b1;
      2'b01:   count_next_s = count_r - 1'b1;
      default: count_next_s = count_r;
    endcase
    rdata_next_s = 32'h0000_0000;
    if (rd_s) begin
      case (sel_s)
        2'd0:    rdata_next_s = empty_s ? 32'h0000_0000 : {24'h00_0000, mem_r[rd_ptr_r]};
        2'd1:    rdata_next_s = {28'h000_0000, frame_err_r, overrun_r, full_s, !empty_s};
        2'd2:    rdata_next_s = {31'h0000_0000, irq_en_r};
        default: rdata_next_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_next_s = 32'h0000_0000;
    end
  end

  // FIFO storage; contents need no reset since count qualifies every read.
  always_ff @(posedge clk_sys_i) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= shift_r;
    end
  end

  // FIFO pointers, sticky status, control register and bus response.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
      irq_en_r    <= 1'b0;
      irq_r       <= 1'b0;
      rvalid_r    <= 1'b0;
      rdata_r     <= 32'h0000_0000;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)     rd_ptr_r <= rd_ptr_r + 1'b1;
      count_r  <= count_next_s;
      irq_en_r <= irq_en_next_s;
      // Computed from next-state values so the interrupt tracks not_empty exactly.
      irq_r    <= irq_en_next_s && (count_next_s != '0);
      rvalid_r <= device_req_i;
      rdata_r  <= rdata_next_s;
      if (ovr_set_s) begin
        overrun_r <= 1'b1;
      end else if (wr_s && (sel_s == 2'd1) && device_wdata_i[2]) begin
        overrun_r <= 1'b0;
      end
      if (ferr_s) begin
        frame_err_r <= 1'b1;
      end else if (wr_s && (sel_s == 2'd1) && device_wdata_i[3]) begin
        frame_err_r <= 1'b0;
      end
    end
  end

  assign device_rvalid_o = rvalid_r;
  assign device_rdata_o  = rdata_r;
  assign rx_irq_o        = irq_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rx_line;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int irq_rise = -1;
  logic [31:0] rd;

  uart_rx #(.ClockFrequency(16), .BaudRate(1), .FifoDepth(4)) dut (
    .clk_sys_i(clk), .rst_sys_ni(rst_n),
    .device_req_i(req), .device_addr_i(addr), .device_we_i(we),
    .device_be_i(be), .device_wdata_i(wdata),
    .device_rvalid_o(rvalid), .device_rdata_o(rdata),
    .uart_rx_i(rx_line), .rx_irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    req = 1'b0;
    chk("rd_rvalid", {31'd0, rvalid}, 32'd1);
    d = rdata;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0; wdata = 32'd0;
    chk("wr_rvalid", {31'd0, rvalid}, 32'd1);
    chk("wr_rdata", rdata, 32'd0);
  endtask

  // Drives one frame; records the cycle (from start-bit fall) at which irq first rises.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        rx_line = bits[b];
        if (irq && irq_rise < 0) irq_rise = b * 16 + c;
      end
    end
  endtask

  task automatic expect_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    chk(tag, v, exp);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; addr = 32'd0; we = 1'b0; be = 4'hF;
    wdata = 32'd0; rx_line = 1'b1;
    idle(3);
    #1;
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    idle(2);
    expect_read("reset_status", 32'h4, 32'h0);
    expect_read("reset_ctrl", 32'h8, 32'h0);
    expect_read("reg_c", 32'hC, 32'h0);

    // Single byte
    send_frame(8'hA5, 1'b1);
    idle(2);
    expect_read("single_status", 32'h4, 32'h1);
    expect_read("single_data", 32'h0, 32'hA5);
    expect_read("single_status_after", 32'h4, 32'h0);

    // Back-to-back until full
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    send_frame(8'h04, 1'b1);
    idle(4);
    expect_read("full_status", 32'h4, 32'h3);
    expect_read("full_d1", 32'h0, 32'h01);
    expect_read("full_d2", 32'h0, 32'h02);
    expect_read("full_d3", 32'h0, 32'h03);
    expect_read("full_d4", 32'h0, 32'h04);
    expect_read("empty_read", 32'h0, 32'h0);
    expect_read("empty_status", 32'h4, 32'h0);

    // Overrun
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1);
    idle(4);
    expect_read("ovr_status", 32'h4, 32'h7);
    bus_write(32'h4, 32'h4);
    expect_read("ovr_cleared", 32'h4, 32'h3);
    for (int i = 0; i < 4; i++) expect_read("ovr_data", 32'h0, 32'h10 + 32'(i));
    expect_read("ovr_drained", 32'h4, 32'h0);

    // Frame error, then a good frame
    send_frame(8'h55, 1'b0);
    rx_line = 1'b1;
    idle(20);
    expect_read("ferr_status", 32'h4, 32'h8);
    send_frame(8'h3C, 1'b1);
    idle(4);
    expect_read("ferr_good_status", 32'h4, 32'h9);
    expect_read("ferr_good_data", 32'h0, 32'h3C);
    bus_write(32'h4, 32'h8);
    expect_read("ferr_cleared", 32'h4, 32'h0);

    // Glitch rejected
    @(negedge clk); rx_line = 1'b0;
    idle(4);
    rx_line = 1'b1;
    idle(40);
    expect_read("glitch_status", 32'h4, 32'h0);

    // Interrupt enabled
    bus_write(32'h8, 32'hFFFF_FFFF);
    expect_read("ctrl_readback", 32'h8, 32'h1);
    irq_rise = -1;
    send_frame(8'h7E, 1'b1);
    idle(2);
    chk("irq_latency_lo", {31'd0, irq_rise >= 155}, 32'd1);
    chk("irq_latency_hi", {31'd0, irq_rise <= 157}, 32'd1);
    chk("irq_high", {31'd0, irq}, 32'd1);
    expect_read("irq_status", 32'h4, 32'h1);
    expect_read("irq_data", 32'h0, 32'h7E);
    chk("irq_dropped", {31'd0, irq}, 32'd0);

    // Interrupt disabled
    bus_write(32'h8, 32'h0);
    irq_rise = -1;
    send_frame(8'h42, 1'b1);
    idle(4);
    chk("irq_disabled", {31'd0, irq_rise < 0}, 32'd1);
    expect_read("noirq_status", 32'h4, 32'h1);
    bus_write(32'h8, 32'h1);
    chk("irq_on_enable", {31'd0, irq}, 32'd1);

    // Reset during data bit 4 of 0xFF
    @(negedge clk); rx_line = 1'b0;
    idle(16);
    rx_line = 1'b1;
    idle(72);
    rst_n = 1'b0;
    #1;
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    chk("midrst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(16);
    send_frame(8'h81, 1'b1);
    idle(4);
    chk("postrst_irq", {31'd0, irq}, 32'd0);
    expect_read("postrst_status", 32'h4, 32'h1);
    expect_read("postrst_data", 32'h0, 32'h81);
    expect_read("postrst_empty", 32'h4, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
